// File: rtl/uarr_l2_rd_ctrl.sv
// Read sequencer for the uarr_l2_mem bank array: steps addr_base through a block of rows,
// waits out the ROM latency and qualifies each dout vector with a valid/ready handshake.
module uarr_l2_rd_ctrl #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8,
  parameter int RD_LAT = 2,
  parameter int STRIDE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  num_steps,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PRESENT,
    FIN
  } state_t;

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic [CNT_W-1:0]   n_reg;
  logic [CNT_W-1:0]   last_idx;

  assign last_idx = n_reg - CNT_W'(1);

  // Backpressure simply freezes addr_base, which keeps the ROM dout stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      n_reg     <= '0;
      addr_base <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_steps != '0) begin
              addr_base <= start_addr;
              out_idx   <= '0;
              n_reg     <= num_steps;
              lat_cnt   <= LAT_W'(RD_LAT);
              busy      <= 1'b1;
              state     <= WAIT;
            end else begin
              done <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (lat_cnt == LAT_W'(1)) begin
            out_valid <= 1'b1;
            out_last  <= (out_idx == last_idx);
            state     <= PRESENT;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        PRESENT: begin
          // Abort takes priority over a handshake in the same cycle.
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_idx == last_idx) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              addr_base <= addr_base + ADDR_W'(STRIDE);
              out_idx   <= out_idx + CNT_W'(1);
              lat_cnt   <= LAT_W'(RD_LAT);
              state     <= WAIT;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uarr_l2_rd_ctrl.sv
// Self-checking bench for uarr_l2_rd_ctrl: a scoreboard of expected (addr, idx, last) vectors
// is filled when a sequence starts and checked by a negedge monitor.
module tb_uarr_l2_rd_ctrl;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 8;
  localparam int RD_LAT = 2;
  localparam int STRIDE = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0]  num_steps;
  logic              abort;
  logic [ADDR_W-1:0] addr_base;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_idx;
  logic              out_last;
  logic              busy;
  logic              done;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  idx;
    logic              last;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   done_cnt;
  int   gap;

  uarr_l2_rd_ctrl #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W),
    .RD_LAT(RD_LAT),
    .STRIDE(STRIDE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .num_steps (num_steps),
    .abort     (abort),
    .addr_base (addr_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares every presented vector against the scoreboard head and pops on handshake.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      gap = 0;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (out_valid === 1'b1) begin
        if (gap != 0) begin
          checks++;
          if (gap != RD_LAT) begin
            failures++;
            $display("[TB] FAIL latency: got %0d cycles, expected %0d", gap, RD_LAT);
          end
        end
        gap = 0;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_vector: addr=%h idx=%0d with empty scoreboard", addr_base, out_idx);
        end else begin
          if (addr_base !== sb[0].addr || out_idx !== sb[0].idx || out_last !== sb[0].last) begin
            failures++;
            $display("[TB] FAIL vector: got addr=%h idx=%0d last=%b, expected addr=%h idx=%0d last=%b",
                     addr_base, out_idx, out_last, sb[0].addr, sb[0].idx, sb[0].last);
          end
          if (out_ready === 1'b1 && abort !== 1'b1) void'(sb.pop_front());
        end
      end else begin
        checks++;
        if (out_last !== 1'b0) begin
          failures++;
          $display("[TB] FAIL last_without_valid: got out_last=%b, expected 0", out_last);
        end
        if (busy === 1'b1) gap++;
        else gap = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n, input bit expect_run);
    start      = 1'b1;
    start_addr = a;
    num_steps  = n;
    if (expect_run) begin
      for (int k = 0; k < int'(n); k++) begin
        exp_t e;
        e.addr = a + ADDR_W'(STRIDE * k);
        e.idx  = CNT_W'(k);
        e.last = (k == int'(n) - 1);
        sb.push_back(e);
      end
    end
    tick();
    start      = 1'b0;
    start_addr = 8'hAA;
    num_steps  = 8'hFF;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (sb.size() == 0 && busy === 1'b0 && done === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (addr_base !== 8'h00 || out_idx !== 8'h00 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: got addr=%h idx=%h v=%b l=%b busy=%b done=%b, expected all 0",
               addr_base, out_idx, out_valid, out_last, busy, done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int d0;
    bit ok;
    d0 = done_cnt;
    out_ready = 1'b1;
    do_start(8'h10, 8'd3, 1'b1);
    checks++;
    if (busy !== 1'b1 || addr_base !== 8'h10) begin
      failures++;
      $display("[TB] FAIL basic_launch: got busy=%b addr=%h, expected busy=1 addr=10", busy, addr_base);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL basic_timeout: got %0d pending vectors, expected 0", sb.size());
    end
    tick();
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("[TB] FAIL basic_done: got %0d done cycles, expected 1", done_cnt - d0);
    end
    checks++;
    if (addr_base !== 8'h14) begin
      failures++;
      $display("[TB] FAIL basic_final_addr: got %h, expected 14", addr_base);
    end
  endtask

  task automatic test_backpressure();
    int d0;
    bit ok;
    bit seen;
    d0 = done_cnt;
    out_ready = 1'b1;
    do_start(8'h10, 8'd3, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (out_idx === 8'd1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    out_ready = 1'b0;
    for (int c = 0; c < 50 && out_valid !== 1'b1; c++) tick();
    checks++;
    if (!seen || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_reach_idx1: got idx=%0d valid=%b, expected idx=1 valid=1", out_idx, out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || addr_base !== 8'h12 || out_idx !== 8'd1) begin
        failures++;
        $display("[TB] FAIL bp_hold: got valid=%b addr=%h idx=%0d, expected valid=1 addr=12 idx=1",
                 out_valid, addr_base, out_idx);
      end
      if (i < 4) tick();
    end
    out_ready = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL bp_timeout: got %0d pending vectors, expected 0", sb.size());
    end
    tick();
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("[TB] FAIL bp_done: got %0d done cycles, expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_wrap();
    int d0;
    bit ok;
    d0 = done_cnt;
    out_ready = 1'b1;
    do_start(8'hFE, 8'd2, 1'b1);
    wait_drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL wrap_timeout: got %0d pending vectors, expected 0", sb.size());
    end
    tick();
    checks++;
    if (done_cnt - d0 != 1 || addr_base !== 8'h00) begin
      failures++;
      $display("[TB] FAIL wrap_done: got done=%0d addr=%h, expected done=1 addr=00", done_cnt - d0, addr_base);
    end
  endtask

  task automatic test_empty();
    int d0;
    bit bad;
    logic [ADDR_W-1:0] a0;
    d0 = done_cnt;
    a0 = addr_base;
    do_start(8'h77, 8'd0, 1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL empty_done: got done=%b busy=%b, expected done=1 busy=0", done, busy);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || done_cnt - d0 != 1 || addr_base !== a0) begin
      failures++;
      $display("[TB] FAIL empty_quiet: got bad=%b done=%0d addr=%h, expected bad=0 done=1 addr=%h",
               bad, done_cnt - d0, addr_base, a0);
    end
  endtask

  task automatic test_abort();
    int d0;
    bit ok;
    bit seen;
    bit bad;
    d0 = done_cnt;
    out_ready = 1'b1;
    do_start(8'h40, 8'd4, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (out_valid === 1'b1 && out_idx === 8'd1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (!seen || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_idle: got seen=%b busy=%b valid=%b done=%b, expected 1 0 0 0",
               seen, busy, out_valid, done);
    end
    sb.delete();
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || done_cnt != d0) begin
      failures++;
      $display("[TB] FAIL abort_quiet: got bad=%b done=%0d, expected bad=0 done=0", bad, done_cnt - d0);
    end
    do_start(8'h50, 8'd2, 1'b1);
    wait_drain(ok);
    tick();
    checks++;
    if (!ok || done_cnt - d0 != 1) begin
      failures++;
      $display("[TB] FAIL abort_restart: got ok=%b done=%0d, expected ok=1 done=1", ok, done_cnt - d0);
    end
  endtask

  task automatic test_reset_and_busy_start();
    int d0;
    bit ok;
    d0 = done_cnt;
    out_ready = 1'b1;
    do_start(8'h20, 8'd2, 1'b1);
    rst_n = 1'b0;
    tick();
    checks++;
    if (addr_base !== 8'h00 || out_idx !== 8'h00 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_state: got addr=%h idx=%h v=%b l=%b busy=%b done=%b, expected all 0",
               addr_base, out_idx, out_valid, out_last, busy, done);
    end
    rst_n = 1'b1;
    sb.delete();
    tick();
    tick();
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_quiet: got done=%0d busy=%b, expected done=0 busy=0", done_cnt - d0, busy);
    end
    do_start(8'h30, 8'd2, 1'b1);
    tick();
    do_start(8'h80, 8'd5, 1'b0);
    wait_drain(ok);
    tick();
    checks++;
    if (!ok || done_cnt - d0 != 1 || addr_base !== 8'h32) begin
      failures++;
      $display("[TB] FAIL busy_start: got ok=%b done=%0d addr=%h, expected ok=1 done=1 addr=32",
               ok, done_cnt - d0, addr_base);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    done_cnt   = 0;
    gap        = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    num_steps  = '0;
    abort      = 1'b0;
    out_ready  = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_empty();
    test_abort();
    test_reset_and_busy_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
